// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped 8N1 UART transmitter with STATUS/DATA registers.
// Build macro UART_FIFO_EN selects a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module uart_tx_ctrl #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cen,
    input  logic        ram_wen,
    input  logic [3:0]  ram_flag,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_sel,
    output logic        txd,
    output logic        tx_busy
);
    // state | meaning
    // IDLE  | line high, pops the buffer head when data is pending
    // START | start bit (low) for BAUD_DIV cycles
    // DATA  | data bits 0..7, LSB first, BAUD_DIV cycles each
    // STOP  | stop bit (high) for BAUD_DIV cycles
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [31:0]   ADDR_STATUS = 32'hE000_0000;
    localparam logic [31:0]   ADDR_DATA   = 32'hE000_0004;
    localparam int unsigned   BW          = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIV - 1);

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift_reg, shift_n;
    logic          txd_c;
    logic          pop;
    logic          full, empty;
    logic [7:0]    head;
    logic          overrun;

    logic hit_status, hit_data, rd_hit, push_req, push_ok, ovr_set, ovr_clr;
    logic [31:0] status_word;
    logic unused_bits;

    assign hit_status  = ram_cen && (ram_addr == ADDR_STATUS);
    assign hit_data    = ram_cen && (ram_addr == ADDR_DATA);
    assign rd_hit      = (hit_status || hit_data) && !ram_wen;
    assign push_req    = hit_data && ram_wen && ram_flag[0];
    assign push_ok     = push_req && (!full || pop);
    assign ovr_set     = push_req && full && !pop;
    assign ovr_clr     = hit_status && ram_wen && ram_flag[0] && ram_wdata[3];
    assign status_word = {28'd0, overrun, tx_busy, empty, full};
    assign unused_bits = ^{ram_flag[3:1], ram_wdata[31:8]};

`ifdef UART_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ram_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

    logic [7:0] hold_data;
    logic       hold_valid;

    assign full  = hold_valid;
    assign empty = !hold_valid;
    assign head  = hold_data;

    // A push in the same cycle as the pop refills the register, so valid stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            hold_data  <= ram_wdata[7:0];
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            uart_sel   <= 1'b0;
            uart_rdata <= '0;
        end else begin
            uart_sel <= rd_hit;
            if (rd_hit) uart_rdata <= hit_status ? status_word : 32'h0;
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        pop     = 1'b0;
        txd_c   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                txd_c = 1'b0;
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                txd_c = shift_reg[bit_cnt];
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    bit_n  = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign txd     = txd_c;
    assign tx_busy = (state != IDLE);

endmodule
